text_cursor_engine: RTL and testbench



---
 rtl/text_pkg.sv | 17 +
 rtl/key_press_detect.sv | 27 ++
 rtl/text_cursor_engine.sv | 163 ++++++++++++++++
 tb/tb_text_cursor_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the text engine family: FSM encoding, glyph geometry
// and character index width.
package text_pkg;

   localparam int GLYPH_W    = 8;
   localparam int GLYPH_H    = 5;
   localparam int CHAR_IDX_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_EMIT,
      ST_ADVANCE
   } state_e;

endpackage

// File: rtl/key_press_detect.sv
// Two-flop synchroniser for an active-low key plus a one-cycle press pulse on
// the synchronised 1->0 transition.
module key_press_detect (
   input  logic clock_i,
   input  logic reset_i,
   input  logic key_n_i,
   output logic press_o
);

   logic sync1_q, sync2_q, prev_q;

   // Reset to the released level so no press is seen when reset drops.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign press_o = prev_q & ~sync2_q;

endmodule

// File: rtl/text_cursor_engine.sv
// Key-driven glyph writer: key0 selects a glyph, key1 streams it row by row
// from the character ROM to the framebuffer, then advances the text cursor.
module text_cursor_engine
   import text_pkg::*;
#(
   parameter int hLength       = 11,
   parameter int vLength       = 11,
   parameter int resHorizontal = 1280,
   parameter int resVertical   = 720,
   parameter int glyphWidth    = GLYPH_W,
   parameter int glyphHeight   = GLYPH_H,
   parameter int numChars      = 26,
   parameter int lineGap       = 2,
   parameter int romAddrWidth  = 12,
   parameter int romLatency    = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    key0,
   input  logic                    key1,
   output logic [romAddrWidth-1:0] romAddress,
   input  logic [glyphWidth-1:0]   romData,
   output logic                    rowValid,
   input  logic                    rowReady,
   output logic [glyphWidth-1:0]   rowData,
   output logic [hLength-1:0]      rowX,
   output logic [vLength-1:0]      rowY,
   output logic [CHAR_IDX_W-1:0]   charIndex,
   output logic                    busy
);

   localparam int CNT_W = (glyphHeight > 1) ? $clog2(glyphHeight) : 1;

   logic key0_press, key1_press;

   key_press_detect u_key0 (
      .clock_i (clock),
      .reset_i (reset),
      .key_n_i (key0),
      .press_o (key0_press)
   );

   key_press_detect u_key1 (
      .clock_i (clock),
      .reset_i (reset),
      .key_n_i (key1),
      .press_o (key1_press)
   );

   state_e                  state_q;
   logic [CHAR_IDX_W-1:0]   char_q;
   logic [CNT_W-1:0]        row_cnt_q;
   logic [1:0]              lat_cnt_q;
   logic [hLength-1:0]      cur_x_q;
   logic [vLength-1:0]      cur_y_q;
   logic [romAddrWidth-1:0] rom_addr_q;
   logic                    row_valid_q;
   logic [glyphWidth-1:0]   row_data_q;
   logic [hLength-1:0]      row_x_q;
   logic [vLength-1:0]      row_y_q;
   logic                    busy_q;

   logic [romAddrWidth-1:0] first_addr_d;
   logic [hLength-1:0]      adv_x_d;
   logic [vLength-1:0]      adv_y_d;
   logic                    last_row;
   int                      nx_i, ny_i;

   always_comb begin
      first_addr_d = romAddrWidth'(int'(char_q) * glyphHeight);
      last_row     = (row_cnt_q == CNT_W'(glyphHeight - 1));
      // Cursor step: next column, wrap to the next text line, wrap to the top.
      nx_i = int'(cur_x_q) + glyphWidth;
      ny_i = int'(cur_y_q);
      if (nx_i + glyphWidth > resHorizontal) begin
         nx_i = 0;
         ny_i = ny_i + glyphHeight + lineGap;
      end
      if (ny_i + glyphHeight > resVertical) begin
         ny_i = 0;
      end
      adv_x_d = hLength'(nx_i);
      adv_y_d = vLength'(ny_i);
   end

   // Row handshake: rowData/rowX/rowY are held while rowValid is high and a
   // row moves on the clock where rowValid && rowReady; rowReady alone is ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         char_q      <= '0;
         row_cnt_q   <= '0;
         lat_cnt_q   <= '0;
         cur_x_q     <= '0;
         cur_y_q     <= '0;
         rom_addr_q  <= '0;
         row_valid_q <= 1'b0;
         row_data_q  <= '0;
         row_x_q     <= '0;
         row_y_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         if (key0_press) begin
            char_q <= (char_q == CHAR_IDX_W'(numChars - 1)) ? '0 : char_q + CHAR_IDX_W'(1);
         end
         case (state_q)
            ST_IDLE: begin
               // The glyph index is captured in the ROM address; later key0
               // presses cannot disturb a write in progress.
               if (key1_press) begin
                  row_cnt_q  <= '0;
                  rom_addr_q <= first_addr_d;
                  busy_q     <= 1'b1;
                  state_q    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               lat_cnt_q <= '0;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (lat_cnt_q == 2'(romLatency - 1)) begin
                  row_data_q  <= romData;
                  row_x_q     <= cur_x_q;
                  row_y_q     <= cur_y_q + vLength'(row_cnt_q);
                  row_valid_q <= 1'b1;
                  state_q     <= ST_EMIT;
               end else begin
                  lat_cnt_q <= lat_cnt_q + 2'd1;
               end
            end
            ST_EMIT: begin
               if (rowReady) begin
                  row_valid_q <= 1'b0;
                  if (last_row) begin
                     state_q <= ST_ADVANCE;
                  end else begin
                     row_cnt_q  <= row_cnt_q + CNT_W'(1);
                     rom_addr_q <= rom_addr_q + romAddrWidth'(1);
                     state_q    <= ST_FETCH;
                  end
               end
            end
            ST_ADVANCE: begin
               cur_x_q <= adv_x_d;
               cur_y_q <= adv_y_d;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign romAddress = rom_addr_q;
   assign rowValid   = row_valid_q;
   assign rowData    = row_data_q;
   assign rowX       = row_x_q;
   assign rowY       = row_y_q;
   assign charIndex  = char_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_text_cursor_engine.sv
// Bench for text_cursor_engine: a full-size instance and a two-glyph-wide
// instance share keys and rowReady; each has its own ROM and reference model.
module tb_text_cursor_engine;

   localparam int H     = 5;
   localparam int W     = 8;
   localparam int NCH   = 26;
   localparam int LINES = (720 - H) / (H + 2) + 1;

   logic clock    = 1'b0;
   logic reset    = 1'b1;
   logic key0     = 1'b1;
   logic key1     = 1'b1;
   logic rowReady = 1'b0;

   logic [11:0] rom_addr  [2];
   logic [7:0]  rom_data  [2];
   logic        row_valid [2];
   logic [7:0]  row_data  [2];
   logic [10:0] row_x     [2];
   logic [10:0] row_y     [2];
   logic [5:0]  char_idx  [2];
   logic        busy      [2];

   always #5 clock = ~clock;

   text_cursor_engine dut (
      .clock(clock), .reset(reset), .key0(key0), .key1(key1),
      .romAddress(rom_addr[0]), .romData(rom_data[0]),
      .rowValid(row_valid[0]), .rowReady(rowReady), .rowData(row_data[0]),
      .rowX(row_x[0]), .rowY(row_y[0]), .charIndex(char_idx[0]), .busy(busy[0])
   );

   text_cursor_engine #(.resHorizontal(16)) dut_s (
      .clock(clock), .reset(reset), .key0(key0), .key1(key1),
      .romAddress(rom_addr[1]), .romData(rom_data[1]),
      .rowValid(row_valid[1]), .rowReady(rowReady), .rowData(row_data[1]),
      .rowX(row_x[1]), .rowY(row_y[1]), .charIndex(char_idx[1]), .busy(busy[1])
   );

   function automatic logic [7:0] rom_fn(input logic [11:0] a);
      logic [7:0] t;
      t = a[7:0] * 8'd37 + 8'd11;
      return t;
   endfunction

   // Synchronous ROM with one clock of latency.
   always @(posedge clock) begin
      rom_data[0] <= rom_fn(rom_addr[0]);
      rom_data[1] <= rom_fn(rom_addr[1]);
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: glyph count per instance gives the cursor as column/line.
   logic [29:0] exp_q0[$];
   logic [29:0] exp_q1[$];
   int g_cnt[2]   = '{0, 0};
   int cols[2]    = '{1280 / W, 16 / W};
   int exp_char   = 0;
   bit bench_busy = 0;

   function automatic logic [29:0] row_word(input int idx, input int r, input int x, input int y);
      logic [11:0] a;
      a = 12'(idx * H + r);
      return {rom_fn(a), 11'(x), 11'(y + r)};
   endfunction

   task automatic model_write(input int idx);
      for (int i = 0; i < 2; i++) begin
         int x, y;
         x = (g_cnt[i] % cols[i]) * W;
         y = ((g_cnt[i] / cols[i]) % LINES) * (H + 2);
         for (int r = 0; r < H; r++) begin
            if (i == 0) exp_q0.push_back(row_word(idx, r, x, y));
            else        exp_q1.push_back(row_word(idx, r, x, y));
         end
         g_cnt[i]++;
      end
   endtask

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   int          xfer[2]  = '{0, 0};
   logic        stall[2] = '{1'b0, 1'b0};
   logic [29:0] held[2];
   int          busy_cycles = 0;

   task automatic mon(input int i);
      logic [29:0] got, exp;
      int depth;
      got = {row_data[i], row_x[i], row_y[i]};
      if (stall[i]) begin
         check("stall_valid", 32'(row_valid[i]), 1);
         check("stall_hold", 32'(got), 32'(held[i]));
      end
      stall[i] = row_valid[i] && !rowReady;
      held[i]  = got;
      if (row_valid[i] && rowReady) begin
         xfer[i]++;
         depth = (i == 0) ? exp_q0.size() : exp_q1.size();
         check("row_expected", 32'(depth != 0), 1);
         if (depth != 0) begin
            exp = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check(i == 0 ? "row_main" : "row_small", 32'(got), 32'(exp));
         end
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         stall[0] = 1'b0;
         stall[1] = 1'b0;
      end else begin
         mon(0);
         mon(1);
         if (busy[0]) busy_cycles++;
      end
   end

   // rowReady driver: 0 = held low, 1 = held high, 2 = random.
   int ready_mode = 1;
   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            0:       rowReady = 1'b0;
            1:       rowReady = 1'b1;
            default: rowReady = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press(input bit k0, input bit k1, input int low);
      if (k1 && !bench_busy) begin
         model_write(exp_char);
         bench_busy = 1;
      end
      if (k0) exp_char = (exp_char + 1) % NCH;
      key0 = !k0;
      key1 = !k1;
      tick(low);
      key0 = 1'b1;
      key1 = 1'b1;
      tick(3);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy[0] && n < 500) begin
         tick(1);
         n++;
      end
      check("idle_main", 32'(busy[0]), 0);
      check("idle_small", 32'(busy[1]), 0);
      bench_busy = 0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!row_valid[0] && n < 100) begin
         tick(1);
         n++;
      end
      check("valid_timeout", 32'(row_valid[0]), 1);
   endtask

   task automatic write_glyph();
      int x0, x1;
      x0 = xfer[0];
      x1 = xfer[1];
      press(0, 1, $urandom_range(1, 3));
      wait_idle();
      check("xfers_main", xfer[0] - x0, H);
      check("xfers_small", xfer[1] - x1, H);
   endtask

   task automatic set_char(input int target);
      while (exp_char != target) press(1, 0, $urandom_range(1, 4));
      check("char_main", 32'(char_idx[0]), exp_char);
      check("char_small", 32'(char_idx[1]), exp_char);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      check("rst_valid", 32'(row_valid[0]), 0);
      check("rst_busy", 32'(busy[0]), 0);
      check("rst_char", 32'(char_idx[0]), 0);
      check("rst_addr", 32'(rom_addr[0]), 0);
      check("rst_x", 32'(row_x[0]), 0);
      check("rst_y", 32'(row_y[0]), 0);
      check("rst_data", 32'(row_data[0]), 0);
      check("rst_valid_s", 32'(row_valid[1]), 0);
      reset = 1'b0;
      tick(3);

      // key0 held low for 10 cycles: one increment, landing on the third edge.
      key0 = 1'b0;
      tick(2);
      check("char_edge2", 32'(char_idx[0]), 0);
      tick(1);
      check("char_edge3", 32'(char_idx[0]), 1);
      exp_char = 1;
      tick(7);
      key0 = 1'b1;
      tick(4);
      check("char_hold", 32'(char_idx[0]), exp_char);
      check("no_row", 32'(row_valid[0]), 0);

      for (int i = 0; i < NCH - 1; i++) press(1, 0, $urandom_range(1, 4));
      check("char_wrap", 32'(char_idx[0]), 0);
      check("char_wrap_model", 32'(char_idx[0]), exp_char);

      // Glyph C with rowReady high: 16 busy cycles.
      set_char(2);
      ready_mode  = 1;
      busy_cycles = 0;
      write_glyph();
      check("busy_cycles", busy_cycles, 16);

      // Long stall on the first row.
      ready_mode = 0;
      press(0, 1, 1);
      wait_valid();
      tick(20);
      ready_mode = 1;
      wait_idle();

      // Simultaneous key0/key1: write uses the old index.
      set_char(5);
      press(1, 1, 2);
      wait_idle();
      check("char_simul", 32'(char_idx[0]), exp_char);

      // key1 again while busy is ignored.
      ready_mode = 2;
      press(0, 1, 1);
      press(0, 1, 1);
      wait_idle();

      // Fill to the end of the first line, then beyond the small screen bottom.
      while (g_cnt[0] < 207) begin
         if ($urandom_range(0, 1) == 1) set_char($urandom_range(0, NCH - 1));
         write_glyph();
      end

      // Reset while a row is waiting in EMIT.
      ready_mode = 0;
      press(0, 1, 1);
      wait_valid();
      tick(3);
      reset = 1'b1;
      tick(1);
      check("rst_emit_valid", 32'(row_valid[0]), 0);
      check("rst_emit_busy", 32'(busy[0]), 0);
      check("rst_emit_char", 32'(char_idx[0]), 0);
      check("rst_emit_valid_s", 32'(row_valid[1]), 0);
      reset = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
      g_cnt[0]   = 0;
      g_cnt[1]   = 0;
      exp_char   = 0;
      bench_busy = 0;
      tick(2);
      ready_mode  = 1;
      busy_cycles = 0;
      set_char(3);
      write_glyph();
      check("busy_cycles_post_rst", busy_cycles, 16);

      tick(4);
      check("drain_main", exp_q0.size(), 0);
      check("drain_small", exp_q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
